pinwheel_ram_arbiter: RTL

- Shares one block_ram port (data RAM, region tag 0x8) between two bus masters.
  - m0: the pinwheel_core data bus.
  - m1: a debug/DMA master.
- Grants are round-robin, with an optional bounded lock for back-to-back bursts.
- Returns read data to the master that issued the read, one cycle after acceptance.
- Sits between the masters and the block_ram tick()/rdata ports in the pinwheel top.

---
 rtl/pinwheel_bus_pkg.sv | 13 +
 rtl/pinwheel_ram_arbiter_rr_arb2.sv | 45 ++++
 rtl/pinwheel_ram_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pinwheel_bus_pkg.sv
// Shared bus constants and types for the pinwheel RAM arbiter.
// Region tags live in addr[31:28].
package pinwheel_bus_pkg;

  localparam logic [3:0] TAG_CODE  = 4'h0;
  localparam logic [3:0] TAG_DATA  = 4'h8;
  localparam logic [3:0] TAG_DEBUG = 4'hF;

  localparam int RAM_ADDR_BITS_DEF = 12;

  typedef logic master_id_t;

endpackage

// File: rtl/pinwheel_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a lock override.
// Purely combinational; state is held by the caller.
module rr_arb2
  import pinwheel_bus_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t last_grant,
  input  logic       lock_hold,
  input  master_id_t lock_owner,
  output logic       gnt_vld,
  output master_id_t gnt_id
);

  logic use_lock;

  assign use_lock = lock_hold && req[lock_owner];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    unique case (1'b1)
      use_lock: begin
        gnt_vld = 1'b1;
        gnt_id  = lock_owner;
      end
      (!use_lock && req == 2'b11): begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end
      (!use_lock && req == 2'b01): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
      (!use_lock && req == 2'b10): begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pinwheel_ram_arbiter.sv
// Two-master arbiter for the data block_ram port.
// Define PINWHEEL_ARB_STATS_EN to add per-master stall counters.
module pinwheel_ram_arbiter
  import pinwheel_bus_pkg::*;
#(
  parameter int         RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int         LOCK_MAX      = 4,
  parameter logic [3:0] RAM_TAG       = TAG_DATA
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic                     m0_req,
  input  logic                     m0_lock,
  input  logic [31:0]              m0_addr,
  input  logic [31:0]              m0_wdata,
  input  logic [3:0]               m0_wmask,
  input  logic                     m0_wren,
  output logic                     m0_ready,
  output logic                     m0_rvalid,
  output logic [31:0]              m0_rdata,
  input  logic                     m1_req,
  input  logic                     m1_lock,
  input  logic [31:0]              m1_addr,
  input  logic [31:0]              m1_wdata,
  input  logic [3:0]               m1_wmask,
  input  logic                     m1_wren,
  output logic                     m1_ready,
  output logic                     m1_rvalid,
  output logic [31:0]              m1_rdata,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic                     ram_cs,
  output logic [31:0]              ram_wdata,
  output logic [3:0]               ram_wmask,
  output logic                     ram_wren,
  input  logic [31:0]              ram_rdata,
  output logic                     bus_err
`ifdef PINWHEEL_ARB_STATS_EN
  ,
  output logic [15:0]              m0_stall_cnt,
  output logic [15:0]              m1_stall_cnt
`endif
);

  logic [1:0]  req;
  master_id_t  last_grant;
  master_id_t  lock_owner;
  master_id_t  rd_owner;
  logic        lock_owner_vld;
  logic [3:0]  lock_cnt;
  logic        lock_hold;
  logic        rd_pend;
  logic        rd_err;

  logic        arb_vld;
  master_id_t  gnt_id;
  logic        gnt;

  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [3:0]  g_wmask;
  logic        g_wren;
  logic        g_lock;
  logic        tag_hit;
  logic        lock_full;
  logic        unused_bits;

  assign req       = {m1_req, m0_req};
  assign lock_full = lock_cnt >= 4'(LOCK_MAX);
  assign lock_hold = lock_owner_vld && !lock_full;

  rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .lock_hold  (lock_hold),
    .lock_owner (lock_owner),
    .gnt_vld    (arb_vld),
    .gnt_id     (gnt_id)
  );

  // Reset gates the grant so nothing is accepted while held.
  assign gnt     = arb_vld && reset_in;

  assign g_addr  = gnt_id ? m1_addr  : m0_addr;
  assign g_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign g_wmask = gnt_id ? m1_wmask : m0_wmask;
  assign g_wren  = gnt_id ? m1_wren  : m0_wren;
  assign g_lock  = gnt_id ? m1_lock  : m0_lock;
  assign tag_hit = g_addr[31:28] == RAM_TAG;

  assign unused_bits = &{1'b0, g_addr};

  assign m0_ready  = gnt && !gnt_id;
  assign m1_ready  = gnt && gnt_id;

  assign ram_cs    = gnt && tag_hit;
  assign ram_wren  = ram_cs && g_wren;
  assign ram_addr  = gnt ? g_addr[RAM_ADDR_BITS+1:2] : '0;
  assign ram_wdata = gnt ? g_wdata : '0;
  assign ram_wmask = gnt ? g_wmask : '0;

  assign m0_rvalid = rd_pend && !rd_owner;
  assign m1_rvalid = rd_pend && rd_owner;
  assign m0_rdata  = (m0_rvalid && !rd_err) ? ram_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !rd_err) ? ram_rdata : '0;

  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      last_grant     <= 1'b1;
      lock_owner     <= 1'b0;
      lock_owner_vld <= 1'b0;
      lock_cnt       <= '0;
      rd_pend        <= 1'b0;
      rd_owner       <= 1'b0;
      rd_err         <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      rd_pend  <= gnt && !g_wren;
      rd_owner <= gnt_id;
      rd_err   <= !tag_hit;
      if (gnt) begin
        last_grant <= gnt_id;
        if (!tag_hit) bus_err <= 1'b1;
        if (g_lock) begin
          if (lock_owner_vld && lock_owner == gnt_id) begin
            if (!lock_full) lock_cnt <= lock_cnt + 4'd1;
          end else begin
            lock_owner     <= gnt_id;
            lock_owner_vld <= 1'b1;
            lock_cnt       <= 4'd1;
          end
        end else begin
          lock_owner_vld <= 1'b0;
          lock_cnt       <= '0;
        end
      end else if (lock_owner_vld && !req[lock_owner]) begin
        lock_owner_vld <= 1'b0;
        lock_cnt       <= '0;
      end
    end
  end

`ifdef PINWHEEL_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (m0_req && !m0_ready && m0_stall_cnt != 16'hFFFF)
        m0_stall_cnt <= m0_stall_cnt + 16'd1;
      if (m1_req && !m1_ready && m1_stall_cnt != 16'hFFFF)
        m1_stall_cnt <= m1_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
